// File: rtl/mul_pkg.sv
// Shared constants for the multiplier-sharing block: operand/product widths
// and the arbiter FSM state encoding.
package mul_pkg;

  localparam int unsigned MUL_W = 4;
  localparam int unsigned P_W   = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

endpackage

// File: rtl/mul.sv
// Unsigned 4x4 combinational multiplier shared by all requesters.
module mul
  import mul_pkg::*;
(
  input  logic [MUL_W-1:0] a,
  input  logic [MUL_W-1:0] b,
  output logic [P_W-1:0]   p
);

  assign p = P_W'(a) * P_W'(b);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NREQ. Returns a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  logic            found;
  logic [IDW-1:0]  sel;
  int unsigned     pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sel   = '0;
    pos   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = (int'(ptr) + k) % NREQ;
      sel = IDW'(pos);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        idx      = sel;
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one 4x4 multiplier among NREQ requesters: round-robin accept in IDLE,
// one cycle of multiply in CALC, registered product held in RESP until taken.
module mul_share_arbiter
  import mul_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [MUL_W*NREQ-1:0] req_a,
  input  logic [MUL_W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [P_W-1:0]        rsp_p,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [MUL_W-1:0] a_q, a_d, b_q, b_d;
  logic [P_W-1:0]   rsp_p_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [P_W-1:0]   prod;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  mul u_mul (
    .a (a_q),
    .b (b_q),
    .p (prod)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      IDLE: begin
        // Grant is masked while reset is held so req_ready reads 0 in reset.
        if (!rst) begin
          req_ready = gnt;
        end
        if (|gnt) begin
          state_d  = CALC;
          id_d     = gnt_idx;
          rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
              a_d = req_a[i*MUL_W +: MUL_W];
              b_d = req_b[i*MUL_W +: MUL_W];
            end
          end
        end
      end
      CALC: begin
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[rsp_id_q] = 1'b1;
        if (rsp_ready[rsp_id_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rsp_p_q  <= '0;
      rsp_id_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      if (state_q == CALC) begin
        rsp_p_q  <= prod;
        rsp_id_q <= id_q;
      end
    end
  end

  assign rsp_p  = rsp_p_q;
  assign rsp_id = rsp_id_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: directed scenarios plus random traffic, all
// checked against a transaction-level model of the sharing protocol.
module tb_mul_share_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [4*NREQ-1:0] req_a, req_b;
  logic [7:0]        rsp_p;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  mul_share_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: who owns the multiplier, edges elapsed since acceptance, product owed.
  int m_ptr, m_owner, m_age, m_prod;
  logic [NREQ-1:0] want, pend;
  int cyc;
  int acc_log[$], acc_tick[$], rsp_log[$];

  function automatic int pick(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    int g;
    logic [NREQ-1:0] er, ev;
    g  = (m_owner < 0) ? pick(req_valid) : -1;
    er = (g >= 0) ? NREQ'(1) << g : '0;
    ev = (m_owner >= 0 && m_age >= 1) ? NREQ'(1) << m_owner : '0;
    check("req_ready", 32'(req_ready), 32'(er));
    check("rsp_valid", 32'(rsp_valid), 32'(ev));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    if (m_owner >= 0 && m_age >= 1) begin
      check("rsp_p", 32'(rsp_p), 32'(m_prod));
      check("rsp_id", 32'(rsp_id), 32'(m_owner));
    end
  endtask

  task automatic model_edge(output int acc, output int done, output int val);
    int g;
    acc = -1; done = -1; val = 0;
    if (m_owner < 0) begin
      g = pick(req_valid);
      if (g >= 0) begin
        m_owner = g;
        m_age   = 0;
        m_prod  = int'(req_a[4*g +: 4]) * int'(req_b[4*g +: 4]);
        m_ptr   = (g + 1) % NREQ;
        acc     = g;
      end
    end else if (m_age >= 1 && rsp_ready[m_owner]) begin
      done    = m_owner;
      val     = m_prod;
      m_owner = -1;
    end else begin
      m_age++;
    end
  endtask

  task automatic tick();
    int acc, done, val;
    @(negedge clk);
    check_outputs();
    model_edge(acc, done, val);
    @(posedge clk);
    #1;
    cyc++;
    if (acc >= 0) begin
      want[acc] = 1'b0;
      pend[acc] = 1'b1;
      acc_log.push_back(acc);
      acc_tick.push_back(cyc);
    end
    if (done >= 0) begin
      pend[done] = 1'b0;
      rsp_log.push_back(val);
    end
    req_valid = want;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    req_a[4*i +: 4] = 4'(a);
    req_b[4*i +: 4] = 4'(b);
  endtask

  // Asserted away from the clock edge; outputs must clear immediately.
  task automatic do_reset(input bit chk);
    rst = 1'b1;
    #1;
    if (chk) begin
      check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_req_ready", 32'(req_ready), 32'(0));
      check("rst_rsp_p", 32'(rsp_p), 32'(0));
      check("rst_rsp_id", 32'(rsp_id), 32'(0));
    end
    m_ptr = 0; m_owner = -1; m_age = 0; m_prod = 0;
    want = '0; pend = '0; req_valid = '0;
    acc_log.delete(); acc_tick.delete(); rsp_log.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random();
    for (int i = 0; i < NREQ; i++) begin
      if (!want[i] && !pend[i] && $urandom_range(0, 2) == 0) begin
        want[i] = 1'b1;
        set_ops(i, $urandom_range(0, 15), $urandom_range(0, 15));
      end else if (want[i] && $urandom_range(0, 7) == 0) begin
        set_ops(i, $urandom_range(0, 15), $urandom_range(0, 15));
      end
      rsp_ready[i] = ($urandom_range(0, 3) != 0);
    end
    req_valid = want;
  endtask

  initial begin
    cyc = 0;
    rst = 1'b1;
    req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    want = '0; pend = '0;
    do_reset(1'b1);

    // Single transaction.
    set_ops(0, 3, 5);
    want = 4'b0001; req_valid = want; rsp_ready = '1;
    #1;
    check("t1_ready", 32'(req_ready), 32'h1);
    ticks(2);
    check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t1_rsp_p", 32'(rsp_p), 32'd15);
    check("t1_rsp_id", 32'(rsp_id), 32'd0);
    ticks(2);

    // Full contention from a fresh pointer.
    do_reset(1'b0);
    for (int i = 0; i < NREQ; i++) set_ops(i, i + 1, 2);
    want = '1; req_valid = want; rsp_ready = '1;
    ticks(14);
    check("t2_count", 32'(acc_log.size()), 32'd4);
    for (int i = 0; i < acc_log.size() && i < 4; i++) begin
      check("t2_order", 32'(acc_log[i]), 32'(i));
      if (i < rsp_log.size()) check("t2_prod", 32'(rsp_log[i]), 32'(2 * (i + 1)));
      if (i > 0) check("t2_gap", 32'(acc_tick[i] - acc_tick[i-1]), 32'd3);
    end

    // Pointer wrap: after granting 1, {0,1} pending must go to 0 first.
    do_reset(1'b0);
    set_ops(1, 4, 4);
    want = 4'b0010; req_valid = want; rsp_ready = '1;
    ticks(4);
    set_ops(0, 1, 1); set_ops(1, 2, 2);
    want = 4'b0011; req_valid = want;
    ticks(7);
    check("t3_count", 32'(acc_log.size()), 32'd3);
    if (acc_log.size() >= 3) begin
      check("t3_first", 32'(acc_log[1]), 32'd0);
      check("t3_second", 32'(acc_log[2]), 32'd1);
    end

    // Backpressure in RESP.
    do_reset(1'b0);
    set_ops(0, 7, 9);
    want = 4'b0001; req_valid = want; rsp_ready = '0;
    ticks(2);
    set_ops(1, 2, 3);
    want[1] = 1'b1; req_valid = want;
    rsp_ready = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_p", 32'(rsp_p), 32'd63);
      check("t4_hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 4'b0001;
    tick();
    check("t4_idle", 32'(busy), 32'd0);
    check("t4_next", 32'(req_ready), 32'h2);
    rsp_ready = '1;
    ticks(3);

    // Extreme operands.
    do_reset(1'b0);
    set_ops(0, 15, 15);
    want = 4'b0001; req_valid = want; rsp_ready = '1;
    ticks(3);
    set_ops(0, 0, 9);
    want = 4'b0001; req_valid = want;
    ticks(3);
    check("t5_count", 32'(rsp_log.size()), 32'd2);
    if (rsp_log.size() >= 2) begin
      check("t5_max", 32'(rsp_log[0]), 32'd225);
      check("t5_zero", 32'(rsp_log[1]), 32'd0);
    end

    // Reset during CALC, then during RESP.
    do_reset(1'b0);
    set_ops(2, 3, 3);
    want = 4'b0100; req_valid = want; rsp_ready = '1;
    tick();
    do_reset(1'b1);
    set_ops(1, 5, 5); set_ops(3, 6, 6);
    want = 4'b1010; req_valid = want;
    #1;
    check("t6_calc_regrant", 32'(req_ready), 32'h2);
    rsp_ready = '0;
    ticks(2);
    do_reset(1'b1);
    set_ops(0, 2, 7); set_ops(3, 6, 6);
    want = 4'b1001; req_valid = want; rsp_ready = '1;
    #1;
    check("t6_resp_regrant", 32'(req_ready), 32'h1);
    ticks(4);

    // Random traffic.
    do_reset(1'b0);
    for (int n = 0; n < 1500; n++) begin
      drive_random();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
